// File: rtl/melody_sequencer.sv
// melody_sequencer: steps a note table at a tick-based tempo, one-shot or looping.
// Ports: clk, rst (sync high), tick, play, loop_en -> note, busy, done, step.
// The note table is supplied as the packed ROM_IMAGE parameter, with step i
// held in bits [i*NOTE_W +: NOTE_W].
// Optional macro MELODY_ARTIC_EN: repeated notes get a trailing rest of
// ARTIC_TICKS ticks so that they sound separate.
module melody_sequencer #(
  parameter int NOTE_W      = 6,
  parameter int SONG_LEN    = 137,
  parameter int STEP_TICKS  = 8,
  parameter int REST_CODE   = 63,
  parameter int ARTIC_TICKS = 1,
  parameter logic [SONG_LEN*NOTE_W-1:0] ROM_IMAGE =
    {SONG_LEN{NOTE_W'(REST_CODE)}}
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic                        play,
  input  logic                        loop_en,
  output logic [NOTE_W-1:0]           note,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(SONG_LEN)-1:0] step
);

  localparam int STEP_W = $clog2(SONG_LEN);
  localparam int CNT_W  = $clog2(STEP_TICKS) + 1;

  localparam logic [STEP_W-1:0] LAST_S = STEP_W'(SONG_LEN - 1);
  localparam logic [CNT_W-1:0]  LAST_T = CNT_W'(STEP_TICKS - 1);
  localparam logic [NOTE_W-1:0] REST   = NOTE_W'(REST_CODE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [STEP_W-1:0]  step_n;
  logic [CNT_W-1:0]   tick_cnt, cnt_n;
  logic               done_n;
  logic               busy_n;
  logic [NOTE_W-1:0]  note_n;

  logic [NOTE_W-1:0]  rom [SONG_LEN];

  for (genvar i = 0; i < SONG_LEN; i++) begin : g_rom
    assign rom[i] = ROM_IMAGE[i*NOTE_W +: NOTE_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      step     <= '0;
      tick_cnt <= '0;
      note     <= REST;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      step     <= step_n;
      tick_cnt <= cnt_n;
      note     <= note_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    step_n  = step;
    cnt_n   = tick_cnt;
    done_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        step_n = '0;
        cnt_n  = '0;
        if (play) state_n = S_PLAY;
      end
      S_PLAY: begin
        // Stopping wins over a tick on the same edge.
        if (!play) begin
          state_n = S_IDLE;
          step_n  = '0;
          cnt_n   = '0;
        end else if (tick) begin
          if (tick_cnt == LAST_T) begin
            cnt_n = '0;
            if (step != LAST_S) begin
              step_n = step + 1'b1;
            end else if (loop_en) begin
              step_n = '0;
            end else begin
              state_n = S_DONE;
              done_n  = 1'b1;
            end
          end else begin
            cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!play) begin
          state_n = S_IDLE;
          step_n  = '0;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        step_n  = '0;
        cnt_n   = '0;
      end
    endcase
  end

`ifdef MELODY_ARTIC_EN
  localparam logic [CNT_W-1:0] ART_START =
    CNT_W'(STEP_TICKS - ARTIC_TICKS);

  logic              last_s;
  logic [STEP_W-1:0] nxt_idx;
  logic              artic;

  // The step after the last one is step 0 only when looping;
  // a one-shot final step never rests.
  assign last_s  = (step == LAST_S);
  assign nxt_idx = last_s ? '0 : step + 1'b1;
  assign artic   = (tick_cnt >= ART_START) &&
                   (rom[nxt_idx] == rom[step]) &&
                   (!last_s || loop_en);
`endif

  // Leaving PLAY silences the note on the same edge; within PLAY
  // the note follows the step register one cycle later.
  always_comb begin
    busy_n = (state_n == S_PLAY);
    note_n = REST;
    if (state_n == S_PLAY) begin
      note_n = rom[step];
`ifdef MELODY_ARTIC_EN
      if (artic) note_n = REST;
`endif
    end
  end

endmodule
